pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage. It is the successor to the fixed 32-bit PC register/adder/mux and adds stall hold, prioritised redirect sources, a configurable reset vector, and an internal circular return-address stack (RAS) for call/return prediction. It sits ahead of instruction memory. It takes resolved redirects from MEM, traps from the exception logic, and call/return hints from decode.

## Interface
Parameters:
- XLEN, 32, address width (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset (bits [1:0] must be 0)
- RAS_DEPTH, 4, return-stack entries (power of 2, ≥ 2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold current PC (fetch not accepted)
- trap_valid  in  1  take trap this cycle
- trap_target  in  XLEN  trap vector
- redirect_valid  in  1  resolved branch/jump from MEM (old PCSrc)
- redirect_target  in  XLEN  resolved target
- call_valid  in  1  decode found a call
- call_target  in  XLEN  call destination
- call_ret_addr  in  XLEN  return address to push
- ret_valid  in  1  decode found a return
- pc  out  XLEN  current fetch PC (registered)
- pc_plus4  out  XLEN  pc + 4, combinational from pc, wraps mod 2^XLEN
- ras_empty  out  1  stack count == 0
- ras_full  out  1  stack count == RAS_DEPTH
- ret_miss  out  1  registered one-cycle pulse: return seen with empty stack

## Operation
- Next-PC priority, highest first:
  1. trap_valid → trap_target; RAS cleared (count = 0).
  2. redirect_valid → redirect_target; RAS unchanged.
  3. stall → pc held; call/ret ignored, RAS unchanged.
  4. call_valid → call_target; push call_ret_addr.
  5. ret_valid, RAS non-empty → popped top entry.
  6. ret_valid, RAS empty → pc_plus4; ret_miss = 1 next cycle.
  7. Otherwise → pc_plus4.
- trap and redirect override stall. Call/ret are dropped whenever a higher source wins.
- call_valid and ret_valid together: call wins and ret is ignored.
- All targets and pushed addresses have bits [1:0] forced to 0 before use.
- RAS: circular buffer with top pointer of width clog2(RAS_DEPTH) and count of width clog2(RAS_DEPTH)+1.
  - Push when full: overwrite the oldest entry (pointer wraps), count stays RAS_DEPTH.
  - Pop: pointer decrements with wrap, count decrements.
  - Pop when empty: no state change.
- Reset: pc = RESET_VECTOR, count = 0, ret_miss = 0. Entry contents are don't-care.

## Timing
- One-cycle latency: a source asserted in cycle N makes pc = target in cycle N+1.
- ras_empty and ras_full reflect the count registered in the current cycle.
- ret_miss is high for exactly the cycle after the offending ret_valid.
- rst wins over every input in the same cycle. Asserting rst mid-stream (for example during stall or a full RAS) yields the reset state on the next edge.
- No combinational path from any input to pc, ras_empty, ras_full, or ret_miss.

## Structure
- Package pc_pkg holds:
  - default XLEN and RESET_VECTOR constants
  - enum pc_sel_e {PC_SEQ, PC_HOLD, PC_TRAP, PC_REDIRECT, PC_CALL, PC_RET}
  - localparam PC_ALIGN_MASK
- Sub-module return_addr_stack holds the circular stack. Its ports are push, pop, clear, push_data, top_data, empty, and full. pc_gen instantiates it and owns the priority select.

## Test plan
- Reset with RESET_VECTOR = 0x100, then 3 free-running cycles → pc = 0x100, 0x104, 0x108, 0x10C; ras_empty = 1.
- stall = 1 for 2 cycles at pc = 0x10 with redirect_valid pulsed in the second cycle to 0x40 → pc holds 0x10, then becomes 0x40.
- call (target 0x200, ret addr 0x14), then ret 2 cycles later → pc = 0x200, 0x204, then 0x14; ras_empty returns to 1.
- RAS_DEPTH = 4: 5 calls with ret addrs A..E, then 5 rets → pc = E, D, C, B. The fifth ret takes pc_plus4 with ret_miss = 1.
- trap_valid, redirect_valid, call_valid, and stall all asserted together with trap_target = 0x80 → pc = 0x80, RAS count = 0.
- redirect_target = 0x43 → pc = 0x40; rst asserted while ras_full = 1 → pc = RESET_VECTOR, ras_empty = 1, ret_miss = 0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the fetch-stage PC generator.
package pc_pkg;

  localparam int          DEFAULT_XLEN         = 32;
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

  // Clears the two low address bits; sliced down to XLEN by users (XLEN <= 64).
  localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_HOLD,
    PC_TRAP,
    PC_REDIRECT,
    PC_CALL,
    PC_RET
  } pc_sel_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: pushes past capacity overwrite the oldest entry.
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top_data,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top_ptr;
  logic [CW-1:0]   count;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign top_data = mem[top_ptr];

  // Power-of-two depth lets the pointer wrap naturally on overflow/underflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_ptr <= '0;
      count   <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      top_ptr <= top_ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !empty) begin
      top_ptr <= top_ptr - PW'(1);
      count   <= count - CW'(1);
    end
  end

  // Entry contents need no reset; only the count marks them valid.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push) mem[top_ptr + PW'(1)] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised next-PC select with stall hold and call/return prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call_valid,
  input  logic [XLEN-1:0] call_target,
  input  logic [XLEN-1:0] call_ret_addr,
  input  logic            ret_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ret_miss
);

  localparam logic [XLEN-1:0] ALIGN = PC_ALIGN_MASK[XLEN-1:0];

  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] ras_top;
  logic            ret_miss_next;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    pc_sel        = PC_SEQ;
    ret_miss_next = 1'b0;
    if (trap_valid)          pc_sel = PC_TRAP;
    else if (redirect_valid) pc_sel = PC_REDIRECT;
    else if (stall)          pc_sel = PC_HOLD;
    else if (call_valid)     pc_sel = PC_CALL;
    else if (ret_valid) begin
      if (!ras_empty) pc_sel = PC_RET;
      else            ret_miss_next = 1'b1;
    end
  end

  always_comb begin
    pc_next = pc_plus4;
    case (pc_sel)
      PC_TRAP:     pc_next = trap_target & ALIGN;
      PC_REDIRECT: pc_next = redirect_target & ALIGN;
      PC_HOLD:     pc_next = pc;
      PC_CALL:     pc_next = call_target & ALIGN;
      PC_RET:      pc_next = ras_top;
      default:     pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      ret_miss <= 1'b0;
    end else begin
      pc       <= pc_next;
      ret_miss <= ret_miss_next;
    end
  end

  return_addr_stack #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (pc_sel == PC_CALL),
    .pop       (pc_sel == PC_RET),
    .clear     (pc_sel == PC_TRAP),
    .push_data (call_ret_addr & ALIGN),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: reset vector, stall/redirect, call/return, RAS overflow, priority, alignment.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, trap_valid, redirect_valid, call_valid, ret_valid;
  logic [31:0] trap_target, redirect_target, call_target, call_ret_addr;
  logic [31:0] pc, pc_plus4;
  logic        ras_empty, ras_full, ret_miss;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .XLEN         (32),
    .RESET_VECTOR (32'h100),
    .RAS_DEPTH    (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call_valid      (call_valid),
    .call_target     (call_target),
    .call_ret_addr   (call_ret_addr),
    .ret_valid       (ret_valid),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .ret_miss        (ret_miss)
  );

  task automatic idle_inputs();
    rst = 0; stall = 0; trap_valid = 0; redirect_valid = 0; call_valid = 0; ret_valid = 0;
    trap_target = 0; redirect_target = 0; call_target = 0; call_ret_addr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h100); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", ras_empty); end
    checks++; if (ret_miss !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b expected 0", ret_miss); end
    checks++; if (pc_plus4 !== 32'h104) begin errors++; $display("FAIL reset_plus4: got %h expected %h", pc_plus4, 32'h104); end
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 4;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL seq_empty: got %b expected 1", ras_empty); end
  endtask

  task automatic test_stall_redirect();
    idle_inputs();
    redirect_valid = 1; redirect_target = 32'h10;
    step();
    redirect_valid = 0;
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL redir_setup: got %h expected %h", pc, 32'h10); end
    stall = 1;
    step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold: got %h expected %h", pc, 32'h10); end
    redirect_valid = 1; redirect_target = 32'h40;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL stall_redirect: got %h expected %h", pc, 32'h40); end
  endtask

  task automatic test_call_ret();
    idle_inputs();
    call_valid = 1; call_target = 32'h200; call_ret_addr = 32'h14;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL call_pc: got %h expected %h", pc, 32'h200); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL call_empty: got %b expected 0", ras_empty); end
    step();
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL call_seq: got %h expected %h", pc, 32'h204); end
    ret_valid = 1;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL ret_pc: got %h expected %h", pc, 32'h14); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b expected 1", ras_empty); end
    checks++; if (ret_miss !== 1'b0) begin errors++; $display("FAIL ret_nomiss: got %b expected 0", ret_miss); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] ra [5];
    ra[0] = 32'h1000; ra[1] = 32'h2000; ra[2] = 32'h3000; ra[3] = 32'h4000; ra[4] = 32'h5000;
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      call_valid = 1; call_target = 32'h300 + 32'(i * 16); call_ret_addr = ra[i];
      step();
      checks++; if (pc !== 32'h300 + 32'(i * 16)) begin errors++; $display("FAIL ovf_call_pc[%0d]: got %h expected %h", i, pc, 32'h300 + 32'(i * 16)); end
      checks++; if (ras_full !== (i >= 3)) begin errors++; $display("FAIL ovf_full[%0d]: got %b expected %b", i, ras_full, (i >= 3)); end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      ret_valid = 1;
      step();
      checks++; if (pc !== ra[4 - i]) begin errors++; $display("FAIL ovf_ret_pc[%0d]: got %h expected %h", i, pc, ra[4 - i]); end
      checks++; if (ret_miss !== 1'b0) begin errors++; $display("FAIL ovf_ret_miss[%0d]: got %b expected 0", i, ret_miss); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b expected 1", ras_empty); end
    step();
    idle_inputs();
    checks++; if (pc !== 32'h2004) begin errors++; $display("FAIL ovf_miss_pc: got %h expected %h", pc, 32'h2004); end
    checks++; if (ret_miss !== 1'b1) begin errors++; $display("FAIL ovf_miss_pulse: got %b expected 1", ret_miss); end
    step();
    checks++; if (ret_miss !== 1'b0) begin errors++; $display("FAIL ovf_miss_clear: got %b expected 0", ret_miss); end
    checks++; if (pc !== 32'h2008) begin errors++; $display("FAIL ovf_after_pc: got %h expected %h", pc, 32'h2008); end
  endtask

  task automatic test_priority();
    idle_inputs();
    call_valid = 1; ret_valid = 1; call_target = 32'h600; call_ret_addr = 32'h700;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h600) begin errors++; $display("FAIL callret_pc: got %h expected %h", pc, 32'h600); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL callret_empty: got %b expected 0", ras_empty); end
    redirect_valid = 1; redirect_target = 32'h900; call_valid = 1; call_target = 32'hA00; call_ret_addr = 32'hB00;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h900) begin errors++; $display("FAIL redir_over_call: got %h expected %h", pc, 32'h900); end
    stall = 1; ret_valid = 1;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h900) begin errors++; $display("FAIL stall_over_ret: got %h expected %h", pc, 32'h900); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL stall_keeps_ras: got %b expected 0", ras_empty); end
    trap_valid = 1; trap_target = 32'h80; redirect_valid = 1; redirect_target = 32'hC00;
    call_valid = 1; call_target = 32'hD00; call_ret_addr = 32'hE00; stall = 1;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL trap_pc: got %h expected %h", pc, 32'h80); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL trap_clear: got %b expected 1", ras_empty); end
  endtask

  task automatic test_align_reset();
    idle_inputs();
    redirect_valid = 1; redirect_target = 32'h43;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL align_redir: got %h expected %h", pc, 32'h40); end
    call_valid = 1; call_target = 32'h203; call_ret_addr = 32'h17;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL align_call: got %h expected %h", pc, 32'h200); end
    ret_valid = 1;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL align_ret: got %h expected %h", pc, 32'h14); end
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFE;
    step();
    idle_inputs();
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      call_valid = 1; call_target = 32'h800; call_ret_addr = 32'h900 + 32'(i);
      step();
    end
    idle_inputs();
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL pre_rst_full: got %b expected 1", ras_full); end
    ret_valid = 1;
    step();
    ret_valid = 0;
    checks++; if (pc !== 32'h900) begin errors++; $display("FAIL aligned_pop: got %h expected %h", pc, 32'h900); end
    call_valid = 1; call_ret_addr = 32'hF00;
    step();
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b expected 1", ras_full); end
    rst = 1; call_valid = 0; ret_valid = 1; stall = 1; redirect_valid = 1; redirect_target = 32'h500;
    step();
    idle_inputs();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, 32'h100); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", ras_empty); end
    checks++; if (ras_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", ras_full); end
    checks++; if (ret_miss !== 1'b0) begin errors++; $display("FAIL rst_miss: got %b expected 0", ret_miss); end
    step();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL rst_resume: got %h expected %h", pc, 32'h104); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_stall_redirect();
    test_call_ret();
    test_ras_overflow();
    test_priority();
    test_align_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
